mem_cell_bank_arb: RTL and testbench
====================================

Name: mem_cell_bank_arb

Overview:
- Clocked controller that shares a bank of DEPTH words of dual-rail latch cells between two requesters, A and B.
- Each word is WIDTH cells with one shared active-low latch enable per word.
- Arbitrates the requesters round-robin, encodes write data to dual-rail, and sequences the latch enable with a settle counter that covers the cell propagation delay.
- Decodes and validity-checks read data.
- Sits between synchronous test/config logic and the asynchronous storage bank.

Parameters:
- WIDTH, 8: data bits per word; the cell bus is 2*WIDTH rails.
- DEPTH, 4: number of words, each with one latch enable.
- AW, 2: address width; DEPTH <= 2**AW.
- SETTLE_CYC, 8: cycles the latch is held open, >= 1. The default covers the cell delay at a 10 ns clock.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- a_req  in  1  requester A transaction request
- a_we  in  1  A: 1 = write, 0 = read
- a_addr  in  AW  A word address
- a_wdata  in  WIDTH  A write data
- a_ack  out  1  A one-cycle completion pulse
- a_rdata  out  WIDTH  A read data, valid with a_ack
- a_err  out  1  A error flag, valid with a_ack
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata, b_err: same as the A ports, for requester B
- cell_rst  out  1  bank reset, forces cells to INIT
- cell_lat_n  out  DEPTH  per-word latch enable; low = transparent
- cell_in  out  2*WIDTH  dual-rail write bus, shared by all words
- cell_out  in  DEPTH*2*WIDTH  dual-rail outputs of all words; word k occupies bits [k*2W +: 2W]

Behaviour:
- Rail encoding per bit, {rail1, rail0}:
  - 10 = logic 1
  - 01 = logic 0
  - 00 = spacer
  - 11 = invalid
- Reset values: all outputs are registered.
  - cell_lat_n = all 1; cell_in = all 00 (spacer).
  - a_ack, b_ack, a_err, b_err = 0; a_rdata, b_rdata = 0.
  - cell_rst = 1. It falls on the first clock edge with rst low.
  - FSM = IDLE; round-robin pointer = "A next".
- Reset mid-operation: abort immediately to the reset values. The latch closes on the same edge, and no ack is issued.
- FSM states: IDLE, SETUP, OPEN, CLOSE, RSAMP, ACK.
- IDLE:
  - Samples a_req/b_req. If only one is high, grant it. If both are high, grant the pointer owner and flip the pointer to the other requester after the grant.
  - Latch we/addr/wdata of the granted requester.
  - If addr >= DEPTH, go to ACK with err=1, rdata=0, and no cell access.
  - Otherwise a write goes to SETUP and a read goes to RSAMP.
- SETUP (1 cycle): cell_in = encoded wdata; all lat_n high.
- OPEN (SETTLE_CYC cycles, counted by a down-counter): cell_lat_n[addr] = 0, all other lat_n = 1, cell_in held.
- CLOSE (1 cycle): all lat_n = 1, cell_in still held.
- ACK entry from CLOSE: cell_in returns to spacer.
- RSAMP (1 cycle): decode word addr from cell_out into rdata.
  - 10 -> 1, 01 -> 0.
  - Any 00 or 11 pair -> that bit = 0 and err = 1.
- ACK (1 cycle):
  - The granted requester's ack = 1, with rdata/err (rdata = 0 for writes, err = 0 for in-range writes).
  - The other requester's ack stays 0.
  - Next state is IDLE.
- Latency from the IDLE edge that samples req to the ack cycle:
  - Write: SETTLE_CYC + 3 cycles.
  - Read: 2 cycles.
  - Out-of-range access: 1 cycle.
- Requesters hold req until ack. Request fields are captured at grant; later changes are ignored.
- Dropping req before ack does not cancel the transaction; the ack is still issued.
- A req still high in the cycle after ack is sampled in IDLE as a new request. Back-to-back transactions are permitted, with a gap of one IDLE cycle.
- At most one cell_lat_n bit is low at any time. A latch never opens in the same cycle that cell_in changes.
- rdata/err hold their last value between acks; they are meaningful only with ack.

Test Plan:
- Reset, then A writes 0xA5 to addr 2 (SETTLE_CYC=8); the cell model echoes cell_in after its delay -> cell_lat_n[2] low for exactly 8 cycles, cell_in = 10_01_10_01_01_10_01_10 during SETUP..CLOSE, a_ack 11 cycles after sampling, a_err=0.
- A reads addr 2 after that write -> a_ack 2 cycles after sampling, a_rdata=0xA5, a_err=0.
- a_req and b_req rise in the same cycle, twice in succession -> A is served first and B second, then B first on the next collision (pointer alternates); b_ack is never high while A's transaction runs.
- B reads addr 5 with DEPTH=4 -> b_ack 1 cycle after sampling, b_err=1, b_rdata=0, no cell_lat_n bit ever low.
- Force word 1's cell_out bit 3 to 11 and bit 0 to 00, then read addr 1 -> err=1, rdata bits 3 and 0 = 0, other bits decoded correctly.
- Assert rst during OPEN of a write -> next edge: all cell_lat_n=1, cell_in=0, no ack, cell_rst=1; after rst falls, a new A request completes normally.

Source files
------------

// File: rtl/mem_cell_bank_arb.sv
// Round-robin two-requester controller for a bank of dual-rail latch cells.
// Sequences write data onto the dual-rail bus and the per-word latch enable; decodes and checks reads.
module mem_cell_bank_arb #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = 2,
  parameter int SETTLE_CYC = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       a_req,
  input  logic                       a_we,
  input  logic [AW-1:0]              a_addr,
  input  logic [WIDTH-1:0]           a_wdata,
  output logic                       a_ack,
  output logic [WIDTH-1:0]           a_rdata,
  output logic                       a_err,
  input  logic                       b_req,
  input  logic                       b_we,
  input  logic [AW-1:0]              b_addr,
  input  logic [WIDTH-1:0]           b_wdata,
  output logic                       b_ack,
  output logic [WIDTH-1:0]           b_rdata,
  output logic                       b_err,
  output logic                       cell_rst,
  output logic [DEPTH-1:0]           cell_lat_n,
  output logic [2*WIDTH-1:0]         cell_in,
  input  logic [DEPTH*2*WIDTH-1:0]   cell_out
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, OPEN, CLOSE, RSAMP, ACK} state_t;

  state_t             state_q, state_d;
  logic               rr_q, rr_d;      // 1 = B has priority on the next collision
  logic               gnt_q, gnt_d;    // 1 = B granted
  logic [AW-1:0]      addr_q, addr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               cell_rst_q;
  logic [DEPTH-1:0]   lat_n_q, lat_n_d;
  logic [2*WIDTH-1:0] cell_in_q, cell_in_d;
  logic               a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic               a_err_q, a_err_d, b_err_q, b_err_d;
  logic [WIDTH-1:0]   a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic               sel_we;
  logic [AW-1:0]      sel_addr;
  logic [WIDTH-1:0]   sel_wdata;
  logic [DEPTH-1:0]   open_mask;
  logic [2*WIDTH-1:0] rd_word;
  logic [WIDTH-1:0]   rd_data;
  logic               rd_bad;
  logic               ack_now, ack_err;
  logic [WIDTH-1:0]   ack_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      cnt_q      <= '0;
      cell_rst_q <= 1'b1;
      lat_n_q    <= '1;
      cell_in_q  <= '0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      a_err_q    <= 1'b0;
      b_err_q    <= 1'b0;
      a_rdata_q  <= '0;
      b_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      cell_rst_q <= 1'b0;
      lat_n_q    <= lat_n_d;
      cell_in_q  <= cell_in_d;
      a_ack_q    <= a_ack_d;
      b_ack_q    <= b_ack_d;
      a_err_q    <= a_err_d;
      b_err_q    <= b_err_d;
      a_rdata_q  <= a_rdata_d;
      b_rdata_q  <= b_rdata_d;
    end
  end

  // Registered outputs are loaded from the next-state decode so they line up with the state they belong to.
  always_comb begin
    state_d   = state_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    lat_n_d   = '1;
    cell_in_d = cell_in_q;
    a_ack_d   = 1'b0;
    b_ack_d   = 1'b0;
    a_err_d   = a_err_q;
    b_err_d   = b_err_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    ack_now   = 1'b0;
    ack_err   = 1'b0;
    ack_data  = '0;

    open_mask = '1;
    rd_word   = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (addr_q == AW'(k)) begin
        open_mask[k] = 1'b0;
        rd_word      = cell_out[k*2*WIDTH +: 2*WIDTH];
      end
    end

    rd_data = '0;
    rd_bad  = 1'b0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      case (rd_word[2*i +: 2])
        2'b10:   rd_data[i] = 1'b1;
        2'b01:   rd_data[i] = 1'b0;
        default: rd_bad     = 1'b1;
      endcase
    end

    case (state_q)
      IDLE: begin
        if (a_req || b_req) begin
          gnt_d = (a_req && b_req) ? rr_q : b_req;
          if (a_req && b_req) rr_d = ~rr_q;
          sel_we    = gnt_d ? b_we    : a_we;
          sel_addr  = gnt_d ? b_addr  : a_addr;
          sel_wdata = gnt_d ? b_wdata : a_wdata;
          addr_d    = sel_addr;
          if (32'(sel_addr) >= DEPTH) begin
            state_d = ACK;
            ack_now = 1'b1;
            ack_err = 1'b1;
          end else if (sel_we) begin
            state_d = SETUP;
            for (int unsigned i = 0; i < WIDTH; i++)
              cell_in_d[2*i +: 2] = sel_wdata[i] ? 2'b10 : 2'b01;
          end else begin
            state_d = RSAMP;
          end
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = CW'(SETTLE_CYC - 1);
        lat_n_d = open_mask;
      end
      OPEN: begin
        if (cnt_q == '0) begin
          state_d = CLOSE;
        end else begin
          cnt_d   = cnt_q - 1'b1;
          lat_n_d = open_mask;
        end
      end
      CLOSE: begin
        state_d   = ACK;
        cell_in_d = '0;
        ack_now   = 1'b1;
      end
      RSAMP: begin
        state_d  = ACK;
        ack_now  = 1'b1;
        ack_data = rd_data;
        ack_err  = rd_bad;
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (ack_now) begin
      if (gnt_d) begin
        b_ack_d   = 1'b1;
        b_rdata_d = ack_data;
        b_err_d   = ack_err;
      end else begin
        a_ack_d   = 1'b1;
        a_rdata_d = ack_data;
        a_err_d   = ack_err;
      end
    end
  end

  assign cell_rst   = cell_rst_q;
  assign cell_lat_n = lat_n_q;
  assign cell_in    = cell_in_q;
  assign a_ack      = a_ack_q;
  assign a_rdata    = a_rdata_q;
  assign a_err      = a_err_q;
  assign b_ack      = b_ack_q;
  assign b_rdata    = b_rdata_q;
  assign b_err      = b_err_q;

endmodule

// File: tb/tb_mem_cell_bank_arb.sv
// Self-checking bench for mem_cell_bank_arb: behavioural cell bank plus a word-level reference model.
module tb_mem_cell_bank_arb;

  localparam int W  = 8;
  localparam int D  = 4;
  localparam int AW = 3;
  localparam int SC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [W-1:0] a_wdata = '0, b_wdata = '0;
  logic a_ack, a_err, b_ack, b_err, cell_rst;
  logic [W-1:0] a_rdata, b_rdata;
  logic [D-1:0] cell_lat_n;
  logic [2*W-1:0] cell_in;
  logic [D*2*W-1:0] cell_out;

  always #5 clk = ~clk;

  mem_cell_bank_arb #(.WIDTH(W), .DEPTH(D), .AW(AW), .SETTLE_CYC(SC)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata), .a_err(a_err),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata), .b_err(b_err),
    .cell_rst(cell_rst), .cell_lat_n(cell_lat_n), .cell_in(cell_in), .cell_out(cell_out)
  );

  // Cell bank: a word tracks cell_in while its enable is low; fmask/fval override rails on the output.
  logic [2*W-1:0] cmem [D];
  logic [2*W-1:0] fmask [D];
  logic [2*W-1:0] fval [D];

  always @(posedge clk) begin
    for (int k = 0; k < D; k++) begin
      if (cell_rst) cmem[k] <= '0;
      else if (!cell_lat_n[k]) cmem[k] <= cell_in;
    end
  end

  always_comb begin
    for (int k = 0; k < D; k++) cell_out[k*2*W +: 2*W] = (cmem[k] & ~fmask[k]) | fval[k];
  end

  // Reference model: word contents, validity and arbitration pointer.
  logic [W-1:0] ref_mem [D];
  bit ref_ok [D];
  bit ref_ptr;

  int n_checks = 0;
  int n_pass = 0;

  // Transaction recorder filled by run().
  bit tx_rq [2];
  bit tx_we [2];
  logic [AW-1:0] tx_ad [2];
  logic [W-1:0] tx_wd [2];
  int ack_cyc [2];
  logic [W-1:0] ack_rd [2];
  bit ack_er [2];
  logic [2*W-1:0] cin_open, cin_ack;
  int lat_low_cnt, multi_low, cin_chg, dbl_ack, spurious, low_bit;
  bit timed_out;

  function automatic int exp_lat(bit we, logic [AW-1:0] ad);
    if (int'(ad) >= D) return 1;
    return we ? SC + 3 : 2;
  endfunction

  task automatic ref_reset();
    for (int k = 0; k < D; k++) begin
      ref_ok[k] = 0;
      ref_mem[k] = '0;
    end
    ref_ptr = 0;
  endtask

  // Applies one access to the model and returns the expected rdata/err.
  task automatic ref_access(input bit we, input logic [AW-1:0] ad, input logic [W-1:0] wd,
                            output logic [W-1:0] rd, output bit er);
    rd = '0;
    er = 0;
    if (int'(ad) >= D) er = 1;
    else if (we) begin
      ref_mem[ad] = wd;
      ref_ok[ad] = 1;
    end else if (ref_ok[ad]) rd = ref_mem[ad];
    else er = 1;
  endtask

  task automatic run();
    int cyc;
    bit pa, pb;
    logic [2*W-1:0] prev_cin;
    pa = tx_rq[0];
    pb = tx_rq[1];
    timed_out = 0;
    ack_cyc[0] = -1;
    ack_cyc[1] = -1;
    lat_low_cnt = 0; multi_low = 0; cin_chg = 0; dbl_ack = 0; spurious = 0; low_bit = -1;
    cin_open = '0; cin_ack = 'x;
    a_req = tx_rq[0]; a_we = tx_we[0]; a_addr = tx_ad[0]; a_wdata = tx_wd[0];
    b_req = tx_rq[1]; b_we = tx_we[1]; b_addr = tx_ad[1]; b_wdata = tx_wd[1];
    prev_cin = cell_in;
    cyc = 0;
    while (pa || pb) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 200) begin
        timed_out = 1;
        a_req = 0;
        b_req = 0;
        break;
      end
      if ($countones(~cell_lat_n) > 1) multi_low++;
      if (cell_lat_n !== '1) begin
        lat_low_cnt++;
        cin_open = cell_in;
        for (int k = 0; k < D; k++) if (!cell_lat_n[k]) low_bit = k;
        if (cell_in !== prev_cin) cin_chg++;
      end
      prev_cin = cell_in;
      if (a_ack && b_ack) dbl_ack++;
      if (a_ack) begin
        if (!pa) spurious++;
        else begin
          ack_cyc[0] = cyc; ack_rd[0] = a_rdata; ack_er[0] = a_err; cin_ack = cell_in;
          pa = 0; a_req = 0;
        end
      end
      if (b_ack) begin
        if (!pb) spurious++;
        else begin
          ack_cyc[1] = cyc; ack_rd[1] = b_rdata; ack_er[1] = b_err; cin_ack = cell_in;
          pb = 0; b_req = 0;
        end
      end
    end
    if (!timed_out) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (cell_rst !== 1'b1) $display("FAIL reset_cell_rst: got %b want 1", cell_rst); else n_pass++;
    n_checks++; if (cell_lat_n !== '1) $display("FAIL reset_lat_n: got %b want 1111", cell_lat_n); else n_pass++;
    n_checks++; if (cell_in !== '0) $display("FAIL reset_cell_in: got %h want 0", cell_in); else n_pass++;
    n_checks++; if ({a_ack, b_ack, a_err, b_err} !== 4'b0) $display("FAIL reset_ack_err: got %b want 0000", {a_ack, b_ack, a_err, b_err}); else n_pass++;
    n_checks++; if ({a_rdata, b_rdata} !== '0) $display("FAIL reset_rdata: got %h want 0", {a_rdata, b_rdata}); else n_pass++;
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    n_checks++; if (cell_rst !== 1'b0) $display("FAIL reset_release: cell_rst got %b want 0", cell_rst); else n_pass++;
    ref_reset();
    @(negedge clk);
  endtask

  task automatic test_write_a5();
    logic [W-1:0] er_d;
    bit er_e;
    tx_rq[0] = 1; tx_we[0] = 1; tx_ad[0] = 2; tx_wd[0] = 8'hA5;
    tx_rq[1] = 0; tx_we[1] = 0; tx_ad[1] = 0; tx_wd[1] = 0;
    run();
    ref_access(1, 2, 8'hA5, er_d, er_e);
    n_checks++; if (timed_out) $display("FAIL wr_timeout: no a_ack within bound"); else n_pass++;
    n_checks++; if (ack_cyc[0] != SC + 3) $display("FAIL wr_latency: got %0d want %0d", ack_cyc[0], SC + 3); else n_pass++;
    n_checks++; if (ack_er[0] !== er_e || ack_rd[0] !== er_d) $display("FAIL wr_err_rdata: got %b/%h want %b/%h", ack_er[0], ack_rd[0], er_e, er_d); else n_pass++;
    n_checks++; if (lat_low_cnt != SC) $display("FAIL wr_open_cycles: got %0d want %0d", lat_low_cnt, SC); else n_pass++;
    n_checks++; if (low_bit != 2) $display("FAIL wr_open_word: got %0d want 2", low_bit); else n_pass++;
    n_checks++; if (cin_open !== 16'b10_01_10_01_01_10_01_10) $display("FAIL wr_cell_in: got %b want 1001100101100110", cin_open); else n_pass++;
    n_checks++; if (cin_ack !== '0) $display("FAIL wr_spacer_at_ack: got %h want 0", cin_ack); else n_pass++;
    n_checks++; if (multi_low != 0 || cin_chg != 0) $display("FAIL wr_latch_rules: multi_low %0d cin_chg %0d want 0 0", multi_low, cin_chg); else n_pass++;
  endtask

  task automatic test_read_back();
    tx_rq[0] = 1; tx_we[0] = 0; tx_ad[0] = 2; tx_wd[0] = 8'h3C;
    tx_rq[1] = 0;
    run();
    n_checks++; if (ack_cyc[0] != 2) $display("FAIL rd_latency: got %0d want 2", ack_cyc[0]); else n_pass++;
    n_checks++; if (ack_rd[0] !== 8'hA5 || ack_er[0] !== 1'b0) $display("FAIL rd_data: got %h/%b want a5/0", ack_rd[0], ack_er[0]); else n_pass++;
    n_checks++; if (lat_low_cnt != 0) $display("FAIL rd_no_open: got %0d want 0", lat_low_cnt); else n_pass++;
  endtask

  task automatic test_collision();
    logic [W-1:0] ed [2];
    bit ee [2];
    int f;
    for (int r = 0; r < 2; r++) begin
      for (int q = 0; q < 2; q++) begin
        tx_rq[q] = 1; tx_we[q] = (r == 0); tx_ad[q] = AW'(q); tx_wd[q] = W'($urandom);
      end
      f = ref_ptr ? 1 : 0;
      ref_ptr = ~ref_ptr;
      ref_access(tx_we[f], tx_ad[f], tx_wd[f], ed[f], ee[f]);
      ref_access(tx_we[1-f], tx_ad[1-f], tx_wd[1-f], ed[1-f], ee[1-f]);
      run();
      n_checks++; if (f != r) $display("FAIL coll_model_ptr: got %0d want %0d", f, r); else n_pass++;
      n_checks++; if (timed_out || !(ack_cyc[f] > 0 && ack_cyc[1-f] > ack_cyc[f]))
        $display("FAIL coll_order%0d: ackA %0d ackB %0d want requester %0d first", r, ack_cyc[0], ack_cyc[1], f); else n_pass++;
      n_checks++; if (ack_cyc[1-f] - ack_cyc[f] - 1 != exp_lat(tx_we[1-f], tx_ad[1-f]))
        $display("FAIL coll_second_latency%0d: got %0d want %0d", r, ack_cyc[1-f] - ack_cyc[f] - 1, exp_lat(tx_we[1-f], tx_ad[1-f])); else n_pass++;
      n_checks++; if (ack_rd[0] !== ed[0] || ack_er[0] !== ee[0] || ack_rd[1] !== ed[1] || ack_er[1] !== ee[1])
        $display("FAIL coll_data%0d: got %h/%b %h/%b want %h/%b %h/%b", r, ack_rd[0], ack_er[0], ack_rd[1], ack_er[1], ed[0], ee[0], ed[1], ee[1]); else n_pass++;
      n_checks++; if (dbl_ack != 0 || spurious != 0) $display("FAIL coll_ack_overlap%0d: dbl %0d spurious %0d want 0 0", r, dbl_ack, spurious); else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    tx_rq[0] = 0;
    tx_rq[1] = 1; tx_we[1] = 0; tx_ad[1] = 5; tx_wd[1] = 8'hFF;
    run();
    n_checks++; if (ack_cyc[1] != 1) $display("FAIL oor_latency: got %0d want 1", ack_cyc[1]); else n_pass++;
    n_checks++; if (ack_er[1] !== 1'b1 || ack_rd[1] !== '0) $display("FAIL oor_err: got %b/%h want 1/00", ack_er[1], ack_rd[1]); else n_pass++;
    n_checks++; if (lat_low_cnt != 0) $display("FAIL oor_no_open: got %0d want 0", lat_low_cnt); else n_pass++;
  endtask

  task automatic test_corrupt_read();
    logic [W-1:0] d, xd;
    bit xe;
    d = W'($urandom) | 8'h09;
    tx_rq[1] = 0;
    tx_rq[0] = 1; tx_we[0] = 1; tx_ad[0] = 1; tx_wd[0] = d;
    ref_access(1, 1, d, xd, xe);
    run();
    fmask[1] = 16'h00C3;
    fval[1]  = 16'h00C0;
    tx_we[0] = 0;
    run();
    fmask[1] = '0;
    fval[1]  = '0;
    n_checks++; if (ack_er[0] !== 1'b1) $display("FAIL bad_rail_err: got %b want 1", ack_er[0]); else n_pass++;
    n_checks++; if (ack_rd[0] !== (d & ~8'h09)) $display("FAIL bad_rail_data: got %h want %h", ack_rd[0], d & ~8'h09); else n_pass++;
  endtask

  task automatic test_reset_mid_write();
    logic [W-1:0] d, xd;
    bit xe;
    a_req = 1; a_we = 1; a_addr = 3; a_wdata = W'($urandom);
    repeat (4) @(posedge clk);
    #1;
    n_checks++; if (cell_lat_n !== 4'b0111) $display("FAIL mid_open_before_rst: got %b want 0111", cell_lat_n); else n_pass++;
    @(negedge clk);
    rst = 1;
    a_req = 0;
    @(posedge clk); #1;
    n_checks++; if (cell_lat_n !== '1 || cell_in !== '0 || cell_rst !== 1'b1)
      $display("FAIL mid_rst_abort: lat_n %b cell_in %h cell_rst %b want 1111 0 1", cell_lat_n, cell_in, cell_rst); else n_pass++;
    repeat (2) begin
      n_checks++; if (a_ack !== 1'b0 || b_ack !== 1'b0) $display("FAIL mid_rst_no_ack: got %b%b want 00", a_ack, b_ack); else n_pass++;
      @(posedge clk); #1;
    end
    @(negedge clk);
    rst = 0;
    ref_reset();
    @(posedge clk);
    @(negedge clk);
    d = W'($urandom);
    tx_rq[1] = 0;
    tx_rq[0] = 1; tx_we[0] = 1; tx_ad[0] = 3; tx_wd[0] = d;
    ref_access(1, 3, d, xd, xe);
    run();
    n_checks++; if (ack_cyc[0] != SC + 3 || ack_er[0] !== 1'b0) $display("FAIL post_rst_write: lat %0d err %b want %0d 0", ack_cyc[0], ack_er[0], SC + 3); else n_pass++;
    tx_we[0] = 0;
    run();
    n_checks++; if (ack_rd[0] !== d || ack_er[0] !== 1'b0) $display("FAIL post_rst_read: got %h/%b want %h/0", ack_rd[0], ack_er[0], d); else n_pass++;
  endtask

  task automatic test_random();
    logic [W-1:0] ed [2];
    bit ee [2];
    int f, who, lat, prev_end;
    for (int t = 0; t < 40; t++) begin
      for (int q = 0; q < 2; q++) begin
        tx_rq[q] = 1'($urandom_range(0, 1));
        tx_we[q] = 1'($urandom_range(0, 1));
        tx_ad[q] = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(D, 7)) : AW'($urandom_range(0, D - 1));
        tx_wd[q] = W'($urandom);
      end
      if (!tx_rq[0] && !tx_rq[1]) tx_rq[$urandom_range(0, 1)] = 1;
      if (tx_rq[0] && tx_rq[1]) begin
        f = ref_ptr ? 1 : 0;
        ref_ptr = ~ref_ptr;
      end else f = tx_rq[0] ? 0 : 1;
      for (int s = 0; s < 2; s++) begin
        who = (s == 0) ? f : 1 - f;
        if (tx_rq[who]) ref_access(tx_we[who], tx_ad[who], tx_wd[who], ed[who], ee[who]);
      end
      run();
      n_checks++; if (timed_out || spurious != 0 || dbl_ack != 0 || multi_low != 0 || cin_chg != 0)
        $display("FAIL rnd_protocol%0d: timeout %b spurious %0d dbl %0d multi_low %0d cin_chg %0d want 0", t, timed_out, spurious, dbl_ack, multi_low, cin_chg); else n_pass++;
      prev_end = 0;
      for (int s = 0; s < 2; s++) begin
        who = (s == 0) ? f : 1 - f;
        if (tx_rq[who]) begin
          lat = ack_cyc[who] - prev_end;
          n_checks++; if (lat != exp_lat(tx_we[who], tx_ad[who]) || ack_rd[who] !== ed[who] || ack_er[who] !== ee[who])
            $display("FAIL rnd_txn%0d_%s: lat %0d data %h err %b want lat %0d data %h err %b", t, who ? "B" : "A",
                     lat, ack_rd[who], ack_er[who], exp_lat(tx_we[who], tx_ad[who]), ed[who], ee[who]); else n_pass++;
          prev_end = ack_cyc[who] + 1;
        end
      end
    end
  endtask

  initial begin
    for (int k = 0; k < D; k++) begin
      fmask[k] = '0;
      fval[k] = '0;
    end
    test_reset();
    test_write_a5();
    test_read_back();
    test_collision();
    test_out_of_range();
    test_corrupt_read();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
